// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Width of the bit segment each pipeline stage resolves.
   function automatic int seg_w(input int n, input int stages);
      return (stages > 0) ? n / stages : n;
   endfunction

   function automatic bit cfg_ok(input int n, input int group, input int stages);
      return (stages >= 1) && (stages <= 8) && (group >= 1) && (n >= 1) &&
             ((n % (stages * group)) == 0);
   endfunction

endpackage

// File: rtl/cla_group.sv
// W-bit carry-lookahead cell: flat sum-of-products carries plus group generate/propagate.
module cla_group #(
   parameter int W = 4
) (
   input  logic [W-1:0] g,
   input  logic [W-1:0] p,
   input  logic         cin,
   output logic [W-1:0] c,
   output logic         gg,
   output logic         gp
);

   // c[i] is the carry into bit i; every term is a direct product, no ripple.
   always_comb begin
      logic t;
      t  = 1'b0;
      c  = '0;
      gg = 1'b0;
      for (int i = 0; i < W; i++) begin
         c[i] = cin;
         for (int m = 0; m < i; m++) c[i] = c[i] & p[m];
         for (int j = 0; j < i; j++) begin
            t = g[j];
            for (int m = j + 1; m < i; m++) t = t & p[m];
            c[i] = c[i] | t;
         end
      end
      for (int j = 0; j < W; j++) begin
         t = g[j];
         for (int m = j + 1; m < W; m++) t = t & p[m];
         gg = gg | t;
      end
   end

   assign gp = &p;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor: one bit segment per stage, carry registered between
// stages, global stall flow control, flags produced with the final segment.
module pipelined_cla_addsub
   import cla_pkg::*;
#(
   parameter int N      = 32,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         op_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic         zero
);

   localparam int SEG = seg_w(N, STAGES);
   localparam int NG  = SEG / GROUP;

   if (!cfg_ok(N, GROUP, STAGES)) begin : g_bad_cfg
      $error("pipelined_cla_addsub: illegal N=%0d GROUP=%0d STAGES=%0d", N, GROUP, STAGES);
   end

   typedef logic [STAGES-1:0][SEG-1:0] word_t;

   logic              stall;
   logic              accept;
   logic [STAGES:1]   vld_pipe;
   logic [N-1:0]      b_eff;
   logic              c0;
   logic              cout_q;
   logic              ovf_q;
   logic              zero_q;

   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign accept    = in_valid & in_ready;
   assign out_valid = vld_pipe[STAGES];

   // Subtraction is A + ~B + 1; a borrow-in removes that +1.
   assign b_eff = (op_sub == OP_SUB) ? ~b : b;
   assign c0    = (op_sub == OP_ADD) ? cin : ~cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      word_t          a_in, b_in, s_in, s_nx;
      word_t          a_q, b_q, s_q;
      logic           c_in, c_nx, c_q;
      logic [SEG-1:0] pv, gv, cb;
      logic [NG-1:0]  ggv, gpv, gc;
      logic           sgg, sgp;
      logic           unused_seg;

      if (k == 0) begin : g_src
         assign a_in = a;
         assign b_in = b_eff;
         assign s_in = '0;
         assign c_in = c0;
      end else begin : g_chain
         assign a_in = g_stg[k-1].a_q;
         assign b_in = g_stg[k-1].b_q;
         assign s_in = g_stg[k-1].s_q;
         assign c_in = g_stg[k-1].c_q;
      end

      assign pv = a_in[k] ^ b_in[k];
      assign gv = a_in[k] & b_in[k];

      for (genvar j = 0; j < NG; j++) begin : g_grp
         cla_group #(.W(GROUP)) u_grp (
            .g   (gv[j*GROUP +: GROUP]),
            .p   (pv[j*GROUP +: GROUP]),
            .cin (gc[j]),
            .c   (cb[j*GROUP +: GROUP]),
            .gg  (ggv[j]),
            .gp  (gpv[j])
         );
      end

      // Second lookahead level across the groups of this segment.
      cla_group #(.W(NG)) u_seg (
         .g   (ggv),
         .p   (gpv),
         .cin (c_in),
         .c   (gc),
         .gg  (sgg),
         .gp  (sgp)
      );

      assign c_nx = sgg | (sgp & c_in);

      always_comb begin
         s_nx    = s_in;
         s_nx[k] = pv ^ cb;
      end

      // Segments other than k only travel through this stage.
      assign unused_seg = ^{a_in, b_in};

      always_ff @(posedge clk) begin
         if (rst) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= 1'b0;
         end else if (!stall) begin
            a_q <= a_in;
            b_q <= b_in;
            s_q <= s_nx;
            c_q <= c_nx;
         end
      end
   end

   logic unused_tail;
   assign unused_tail = ^{g_stg[STAGES-1].a_q, g_stg[STAGES-1].b_q, g_stg[STAGES-1].c_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else if (!stall) begin
         vld_pipe[1] <= accept;
         for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
         cout_q <= g_stg[STAGES-1].c_nx;
         ovf_q  <= g_stg[STAGES-1].c_nx ^ g_stg[STAGES-1].cb[SEG-1];
         zero_q <= ~|g_stg[STAGES-1].s_nx;
      end
   end

   assign sum  = g_stg[STAGES-1].s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule
